// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a single-port data memory.
// Sub-word stores are performed as a read-modify-write over two memory cycles.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [3:0]        p0_be,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [3:0]        p1_be,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RMW_WR = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t            state_r;
    state_t            state_s;
    logic              rr_ptr_r;
    logic              port_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [3:0]        be_r;
    logic [DATA_W-1:0] rdata_r;
    logic [DATA_W-1:0] merge_r;
    logic              grant_s;
    logic              gport_s;
    logic              partial_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] new_w,
                                                input logic [31:0] old_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Arbitration: a lone requester wins, otherwise rr_ptr picks the port.
    always_comb begin
        grant_s   = p0_valid | p1_valid;
        partial_s = (be_r != 4'hF) && (be_r != 4'h0);
        if (p0_valid && p1_valid) begin
            gport_s = rr_ptr_r;
        end else begin
            gport_s = p1_valid;
        end
    end

    // State register plus request/response latches.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            rr_ptr_r <= 1'b0;
            port_r   <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= {DATA_W{1'b0}};
            be_r     <= 4'h0;
            rdata_r  <= {DATA_W{1'b0}};
            merge_r  <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        port_r   <= gport_s;
                        rr_ptr_r <= ~gport_s;
                        if (gport_s) begin
                            we_r    <= p1_we;
                            addr_r  <= p1_addr & WORD_MASK;
                            wdata_r <= p1_wdata;
                            be_r    <= p1_be;
                        end else begin
                            we_r    <= p0_we;
                            addr_r  <= p0_addr & WORD_MASK;
                            wdata_r <= p0_wdata;
                            be_r    <= p0_be;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_r) begin
                        rdata_r <= mem_rd;
                    end else if (partial_s) begin
                        merge_r <= mem_rd;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and outputs; reset gates every strobe so an abort issues nothing.
    always_comb begin
        state_s   = state_r;
        p0_ready  = 1'b0;
        p1_ready  = 1'b0;
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        p0_rdata  = {DATA_W{1'b0}};
        p1_rdata  = {DATA_W{1'b0}};
        mem_we    = 1'b0;
        mem_a     = {ADDR_W{1'b0}};
        mem_wd    = {DATA_W{1'b0}};
        busy      = (state_r != IDLE);
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    p0_ready = reset & ~gport_s;
                    p1_ready = reset & gport_s;
                    state_s  = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                mem_a = addr_r;
                if (we_r && partial_s) begin
                    state_s = RMW_WR;
                end else if (we_r && (be_r == 4'hF)) begin
                    mem_we  = reset;
                    mem_wd  = wdata_r;
                    state_s = RESP;
                end else begin
                    state_s = RESP;
                end
            end
            RMW_WR: begin
                mem_we  = reset;
                mem_a   = addr_r;
                mem_wd  = merge_bytes(wdata_r, merge_r, be_r);
                state_s = RESP;
            end
            RESP: begin
                // Writes always answer with zero data.
                if (port_r) begin
                    p1_rvalid = reset;
                    p1_rdata  = we_r ? {DATA_W{1'b0}} : rdata_r;
                end else begin
                    p0_rvalid = reset;
                    p0_rdata  = we_r ? {DATA_W{1'b0}} : rdata_r;
                end
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural word memory attached.
// Each check is an immediate assertion against a hand-computed value.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        p0_valid, p0_ready, p0_we, p0_rvalid;
    logic [7:0]  p0_addr;
    logic [31:0] p0_wdata, p0_rdata;
    logic [3:0]  p0_be;
    logic        p1_valid, p1_ready, p1_we, p1_rvalid;
    logic [7:0]  p1_addr;
    logic [31:0] p1_wdata, p1_rdata;
    logic [3:0]  p1_be;
    logic        mem_we;
    logic [7:0]  mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        busy;

    logic [31:0] mem [0:63];
    int          total;
    int          bad;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_be(p0_be), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_be(p1_be), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'h0BADF00D;
        mem[8]  = 32'h11223344;
        mem[12] = 32'h55667788;
        reset = 1'b0;
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 8'h00; p0_wdata = 32'h0; p0_be = 4'h0;
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 8'h00; p1_wdata = 32'h0; p1_be = 4'h0;

        // Reset held two cycles with both ports requesting
        tick(); tick(); #1;
        chk("rst_p0_ready", {31'd0, p0_ready}, 32'd0);
        chk("rst_p1_ready", {31'd0, p1_ready}, 32'd0);
        chk("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
        chk("rst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Release: p0 full write wins over p1 read of 0x00
        reset = 1'b1;
        p0_we = 1'b1; p0_addr = 8'h10; p0_wdata = 32'hDEADBEEF; p0_be = 4'hF;
        #1;
        chk("first_grant_p0", {31'd0, p0_ready}, 32'd1);
        chk("first_grant_p1", {31'd0, p1_ready}, 32'd0);
        tick(); p0_valid = 1'b0; #1;
        chk("fw_mem_we", {31'd0, mem_we}, 32'd1);
        chk("fw_mem_a", {24'd0, mem_a}, 32'h10);
        chk("fw_mem_wd", mem_wd, 32'hDEADBEEF);
        chk("fw_busy", {31'd0, busy}, 32'd1);
        chk("fw_p1_ready_busy", {31'd0, p1_ready}, 32'd0);
        tick(); #1;
        chk("fw_rvalid", {31'd0, p0_rvalid}, 32'd1);
        chk("fw_rdata", p0_rdata, 32'd0);
        chk("fw_mem_we_once", {31'd0, mem_we}, 32'd0);
        chk("fw_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
        chk("fw_stored", mem[4], 32'hDEADBEEF);

        // Pending p1 read is served next
        tick(); #1;
        chk("p1_pending_ready", {31'd0, p1_ready}, 32'd1);
        tick(); p1_valid = 1'b0; #1;
        tick(); #1;
        chk("p1_rd_rvalid", {31'd0, p1_rvalid}, 32'd1);
        chk("p1_rd_rdata", p1_rdata, 32'h0BADF00D);
        chk("p1_rd_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);

        // p0 reads 0x13 (low bits ignored)
        tick();
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 8'h13; p0_be = 4'h0; #1;
        chk("rd_ready", {31'd0, p0_ready}, 32'd1);
        tick(); p0_valid = 1'b0; #1;
        chk("rd_mem_a", {24'd0, mem_a}, 32'h10);
        chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rd_rvalid_early", {31'd0, p0_rvalid}, 32'd0);
        tick(); #1;
        chk("rd_rvalid", {31'd0, p0_rvalid}, 32'd1);
        chk("rd_rdata", p0_rdata, 32'hDEADBEEF);

        // p1 partial write to 0x20, be=0101
        tick();
        p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 8'h20; p1_wdata = 32'hAABBCCDD; p1_be = 4'b0101; #1;
        chk("pw_ready", {31'd0, p1_ready}, 32'd1);
        tick(); p1_valid = 1'b0; #1;
        chk("pw_acc_mem_we", {31'd0, mem_we}, 32'd0);
        chk("pw_acc_rvalid", {31'd0, p1_rvalid}, 32'd0);
        tick(); #1;
        chk("pw_rmw_mem_we", {31'd0, mem_we}, 32'd1);
        chk("pw_rmw_mem_a", {24'd0, mem_a}, 32'h20);
        chk("pw_rmw_mem_wd", mem_wd, 32'h11BB33DD);
        chk("pw_rmw_rvalid", {31'd0, p1_rvalid}, 32'd0);
        tick(); #1;
        chk("pw_rvalid", {31'd0, p1_rvalid}, 32'd1);
        chk("pw_rdata", p1_rdata, 32'd0);
        chk("pw_resp_mem_we", {31'd0, mem_we}, 32'd0);
        chk("pw_stored", mem[8], 32'h11BB33DD);

        // Contention: both read continuously, grants alternate p0,p1,p0,p1
        tick();
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 8'h10;
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 8'h20; p1_be = 4'h0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("ct_p0_ready", {31'd0, p0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("ct_p1_ready", {31'd0, p1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            tick(); tick(); #1;
            chk("ct_p0_rvalid", {31'd0, p0_rvalid}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("ct_p1_rvalid", {31'd0, p1_rvalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k % 2 == 0) chk("ct_p0_rdata", p0_rdata, 32'hDEADBEEF);
            else            chk("ct_p1_rdata", p1_rdata, 32'h11BB33DD);
            tick();
        end

        // be=0 write: no memory write, response with zero data
        p1_valid = 1'b0;
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 8'h10; p0_wdata = 32'hFFFFFFFF; p0_be = 4'h0; #1;
        chk("be0_ready", {31'd0, p0_ready}, 32'd1);
        tick(); p0_valid = 1'b0; #1;
        chk("be0_acc_mem_we", {31'd0, mem_we}, 32'd0);
        tick(); #1;
        chk("be0_rvalid", {31'd0, p0_rvalid}, 32'd1);
        chk("be0_rdata", p0_rdata, 32'd0);
        chk("be0_mem_we", {31'd0, mem_we}, 32'd0);
        chk("be0_unchanged", mem[4], 32'hDEADBEEF);

        // Abort a partial write during RMW_WR
        tick();
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 8'h30; p0_wdata = 32'hAAAAAAAA; p0_be = 4'b1000; #1;
        chk("ab_ready", {31'd0, p0_ready}, 32'd1);
        tick(); p0_valid = 1'b0; #1;
        tick(); #1;
        chk("ab_in_rmw", mem_wd, 32'hAA667788);
        reset = 1'b0; #1;
        chk("ab_mem_we_gated", {31'd0, mem_we}, 32'd0);
        tick(); #1;
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
        chk("ab_mem_kept", mem[12], 32'h55667788);
        reset = 1'b1;
        tick(); #1;
        chk("ab_no_rvalid_later", {31'd0, p0_rvalid}, 32'd0);
        chk("ab_idle_after", {31'd0, busy}, 32'd0);
        p0_valid = 1'b1; p0_we = 1'b0; p1_valid = 1'b1; #1;
        chk("ab_rr_p0", {31'd0, p0_ready}, 32'd1);
        chk("ab_rr_p1", {31'd0, p1_ready}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
